// File: rtl/kogge_stone_pkg.sv
// Shared constants, FSM state encoding and the directed corner-vector table
// for the Kogge-Stone adder BIST engine.
package kogge_stone_pkg;

  localparam int NUM_DIRECTED  = 4;
  localparam int MAX_PRECISION = 64;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] DEFAULT_TAPS = 16'hB400;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t APPLY = 2'd1;
  localparam state_t CHECK = 2'd2;
  localparam state_t DONE  = 2'd3;

  // Returns {A, B}, each right-aligned in a MAX_PRECISION-bit field.
  function automatic logic [2*MAX_PRECISION-1:0] directedVector(input logic [1:0] idx,
                                                                input int unsigned width);
    logic [MAX_PRECISION-1:0] maxVal;
    logic [MAX_PRECISION-1:0] one;
    maxVal = '1;
    maxVal = maxVal >> (MAX_PRECISION - width);
    one    = '0;
    one[0] = 1'b1;
    case (idx)
      2'd0:    directedVector = '0;
      2'd1:    directedVector = {maxVal, {MAX_PRECISION{1'b0}}};
      2'd2:    directedVector = {maxVal, one};
      default: directedVector = {maxVal, maxVal};
    endcase
  endfunction

endpackage

// File: rtl/kogge_stone_bist_lfsr.sv
// Galois LFSR used as the pseudo-random operand source; a zero seed is
// replaced by 1 so the register can never lock up in the all-zero state.
module lfsr_galois #(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = '0,
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] state_o
);

  localparam logic [WIDTH-1:0] SAFE_SEED = (SEED == '0) ? WIDTH'(1) : SEED;

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;

  always_comb begin
    state_d = state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SAFE_SEED;
    end else if (load_i) begin
      state_q <= SAFE_SEED;
    end else if (step_i) begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/kogge_stone_bist.sv
// BIST engine: drives directed then LFSR operands into a combinational adder,
// compares against a behavioural sum and records errors and the first failure.
module kogge_stone_bist
  import kogge_stone_pkg::*;
#(
  parameter int                       PRECISION     = 8,
  parameter int                       NUM_RANDOM    = 16,
  parameter int                       SETTLE_CYCLES = 1,
  parameter logic [2*PRECISION-1:0]   LFSR_SEED     = DEFAULT_SEED,
  parameter logic [2*PRECISION-1:0]   LFSR_TAPS     = DEFAULT_TAPS,
  parameter int                       ERR_W         = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  output logic [PRECISION-1:0] operand_a_o,
  output logic [PRECISION-1:0] operand_b_o,
  input  logic [PRECISION-1:0] result_i,
  input  logic                 overflow_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [ERR_W-1:0]     error_count_o,
  output logic [15:0]          vector_count_o,
  output logic [PRECISION-1:0] fail_a_o,
  output logic [PRECISION-1:0] fail_b_o
);

  localparam int          LW          = 2 * PRECISION;
  localparam logic [15:0] LAST_IDX    = 16'(NUM_DIRECTED + NUM_RANDOM - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] DIR_COUNT   = 16'(NUM_DIRECTED);

  state_t               state_q, state_d;
  logic [15:0]          idx_q, idx_d;
  logic [15:0]          settle_q, settle_d;
  logic [PRECISION-1:0] a_q, a_d;
  logic [PRECISION-1:0] b_q, b_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic [15:0]          vcnt_q, vcnt_d;
  logic [PRECISION-1:0] failA_q, failA_d;
  logic [PRECISION-1:0] failB_q, failB_d;
  logic                 failSeen_q, failSeen_d;

  logic                 lfsrLoad, lfsrStep;
  logic [LW-1:0]        lfsrState;
  logic [15:0]          loadIdx;
  logic [2*MAX_PRECISION-1:0] dirVec;
  logic [PRECISION-1:0] vecA, vecB;
  logic [PRECISION:0]   golden;
  logic                 mismatch;

  lfsr_galois #(
    .WIDTH (LW),
    .TAPS  (LFSR_TAPS),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (lfsrLoad),
    .step_i  (lfsrStep),
    .state_o (lfsrState)
  );

  // A start always loads vector 0; otherwise the next vector is idx+1.
  always_comb begin
    loadIdx = ((state_q == IDLE) || (state_q == DONE)) ? 16'd0 : idx_q + 16'd1;
  end

  // Random vectors take the current LFSR state; it steps on the same load.
  always_comb begin
    dirVec = directedVector(loadIdx[1:0], PRECISION);
    if (loadIdx < DIR_COUNT) begin
      vecA = dirVec[MAX_PRECISION +: PRECISION];
      vecB = dirVec[0 +: PRECISION];
    end else begin
      vecA = lfsrState[LW-1:PRECISION];
      vecB = lfsrState[PRECISION-1:0];
    end
  end

  // Case-inequality makes X or Z on the adder outputs count as a mismatch.
  always_comb begin
    golden   = {1'b0, a_q} + {1'b0, b_q};
    mismatch = (result_i !== golden[PRECISION-1:0]) || (overflow_i !== golden[PRECISION]);
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    settle_d   = settle_q;
    a_d        = a_q;
    b_d        = b_q;
    err_d      = err_q;
    vcnt_d     = vcnt_q;
    failA_d    = failA_q;
    failB_d    = failB_q;
    failSeen_d = failSeen_q;
    lfsrLoad   = 1'b0;
    lfsrStep   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d    = APPLY;
          idx_d      = 16'd0;
          settle_d   = 16'd0;
          err_d      = '0;
          vcnt_d     = 16'd0;
          failA_d    = '0;
          failB_d    = '0;
          failSeen_d = 1'b0;
          lfsrLoad   = 1'b1;
          a_d        = vecA;
          b_d        = vecB;
        end
      end
      APPLY: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = CHECK;
          settle_d = 16'd0;
        end else begin
          settle_d = settle_q + 16'd1;
        end
      end
      default: begin
        vcnt_d = vcnt_q + 16'd1;
        if (mismatch) begin
          if (err_q != '1) begin
            err_d = err_q + 1'b1;
          end
          if (!failSeen_q) begin
            failA_d    = a_q;
            failB_d    = b_q;
            failSeen_d = 1'b1;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          state_d  = APPLY;
          idx_d    = loadIdx;
          a_d      = vecA;
          b_d      = vecB;
          lfsrStep = (loadIdx >= DIR_COUNT);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      idx_q      <= 16'd0;
      settle_q   <= 16'd0;
      a_q        <= '0;
      b_q        <= '0;
      err_q      <= '0;
      vcnt_q     <= 16'd0;
      failA_q    <= '0;
      failB_q    <= '0;
      failSeen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      settle_q   <= settle_d;
      a_q        <= a_d;
      b_q        <= b_d;
      err_q      <= err_d;
      vcnt_q     <= vcnt_d;
      failA_q    <= failA_d;
      failB_q    <= failB_d;
      failSeen_q <= failSeen_d;
    end
  end

  assign operand_a_o    = a_q;
  assign operand_b_o    = b_q;
  assign busy_o         = (state_q == APPLY) || (state_q == CHECK);
  assign done_o         = (state_q == DONE);
  assign pass_o         = (state_q == DONE) && (err_q == '0);
  assign error_count_o  = err_q;
  assign vector_count_o = vcnt_q;
  assign fail_a_o       = failA_q;
  assign fail_b_o       = failB_q;

endmodule
